// File: rtl/sram_controller_pkg.sv
// Shared types and sizing for the 32-bit-over-16-bit SRAM controller.
package sram_ctrl_pkg;
   localparam int SRAM_ADDR_W    = 18;
   localparam int SRAM_DQ_W      = 16;
   localparam int WORD_ADDR_W    = SRAM_ADDR_W - 1;
   localparam int ACCESS_CYC_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;
endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response plus SRAM pin bundle for sram_controller.
interface sram_controller_if;
   import sram_ctrl_pkg::*;

   logic                   MEM_R_EN;
   logic                   MEM_W_EN;
   logic [31:0]            Address;
   logic [31:0]            Write_data;
   logic [31:0]            read_data;
   logic                   ready;
   logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
   logic                   SRAM_WE_N;
   logic [SRAM_DQ_W-1:0]   SRAM_DQ_OUT;
   logic                   SRAM_DQ_OE;
   logic [SRAM_DQ_W-1:0]   SRAM_DQ_IN;

   modport master (
      output MEM_R_EN, MEM_W_EN, Address, Write_data, SRAM_DQ_IN,
      input  read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE
   );

   modport slave (
      input  MEM_R_EN, MEM_W_EN, Address, Write_data, SRAM_DQ_IN,
      output read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE
   );
endinterface

// File: rtl/sram_controller_read_buffer.sv
// One-entry last-read buffer: word address, 32-bit data, valid bit.
module sram_read_buffer
   import sram_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WORD_ADDR_W-1:0] lookup_addr_i,
   output logic                   hit_o,
   output logic [31:0]            data_o,
   input  logic                   fill_i,
   input  logic [WORD_ADDR_W-1:0] fill_addr_i,
   input  logic [31:0]            fill_data_i,
   input  logic                   inval_i
);
   logic                   valid_q;
   logic [WORD_ADDR_W-1:0] addr_q;
   logic [31:0]            data_q;

   // Refill on every completed SRAM read; drop the entry when it is overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (fill_i) begin
         valid_q <= 1'b1;
         addr_q  <= fill_addr_i;
         data_q  <= fill_data_i;
      end else if (inval_i) begin
         valid_q <= 1'b0;
      end
   end

   assign hit_o  = valid_q && (addr_q == lookup_addr_i);
   assign data_o = data_q;
endmodule

// File: rtl/sram_controller.sv
// 32-bit MEM-stage access split into two 16-bit SRAM half-accesses.
// Optional last-read buffer enabled by macro SRAM_READ_BUFFER_EN.
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int ACCESS_CYC = ACCESS_CYC_DEF
) (
   input  logic           clk,
   input  logic           rst,
   sram_controller_if.slave bus
);
   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYC - 1);

   state_e                 state_q;
   logic [3:0]             cnt_q;
   logic                   is_wr_q;
   logic [31:0]            rdata_q;
   logic [15:0]            wdata_hi_q;
   logic [SRAM_ADDR_W-1:0] addr_q;
   logic                   we_n_q;
   logic [SRAM_DQ_W-1:0]   dq_out_q;
   logic                   oe_q;

   logic                   wr_req, rd_req, req, last;
   logic [14:0]            unused_addr_hi;

   // A simultaneous read+write request is treated as a write.
   assign wr_req         = bus.MEM_W_EN;
   assign rd_req         = bus.MEM_R_EN & ~bus.MEM_W_EN;
   assign req            = bus.MEM_R_EN | bus.MEM_W_EN;
   assign last           = (cnt_q == LAST_CNT);
   assign unused_addr_hi = bus.Address[31:17];

`ifdef SRAM_READ_BUFFER_EN
   logic        buf_hit;
   logic [31:0] buf_data;
   logic        buf_fill, buf_inval;

   assign buf_fill  = (state_q == HIGH) && last && !is_wr_q;
   assign buf_inval = (state_q == IDLE) && wr_req && buf_hit;

   sram_read_buffer u_rbuf (
      .clk           (clk),
      .rst_n         (rst),
      .lookup_addr_i (bus.Address[WORD_ADDR_W-1:0]),
      .hit_o         (buf_hit),
      .data_o        (buf_data),
      .fill_i        (buf_fill),
      .fill_addr_i   (addr_q[SRAM_ADDR_W-1:1]),
      .fill_data_i   ({bus.SRAM_DQ_IN, rdata_q[15:0]}),
      .inval_i       (buf_inval)
   );
`else
   logic        buf_hit;
   logic [31:0] buf_data;

   assign buf_hit  = 1'b0;
   assign buf_data = '0;
`endif

   // Access sequencer; request fields are latched at start so a dropped request still completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_wr_q    <= 1'b0;
         rdata_q    <= '0;
         wdata_hi_q <= '0;
         addr_q     <= '0;
         we_n_q     <= 1'b1;
         dq_out_q   <= '0;
         oe_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req) begin
               cnt_q   <= '0;
               is_wr_q <= wr_req;
               if (rd_req && buf_hit) begin
                  state_q <= DONE;
                  rdata_q <= buf_data;
               end else begin
                  state_q    <= LOW;
                  addr_q     <= {bus.Address[WORD_ADDR_W-1:0], 1'b0};
                  we_n_q     <= ~wr_req;
                  oe_q       <= wr_req;
                  wdata_hi_q <= bus.Write_data[31:16];
                  if (wr_req) dq_out_q <= bus.Write_data[15:0];
               end
            end
            LOW: if (last) begin
               cnt_q     <= '0;
               state_q   <= HIGH;
               addr_q[0] <= 1'b1;
               if (is_wr_q) dq_out_q      <= wdata_hi_q;
               else         rdata_q[15:0] <= bus.SRAM_DQ_IN;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
            HIGH: if (last) begin
               cnt_q   <= '0;
               state_q <= DONE;
               we_n_q  <= 1'b1;
               oe_q    <= 1'b0;
               if (!is_wr_q) rdata_q[31:16] <= bus.SRAM_DQ_IN;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready       = ~req | (state_q == DONE);
   assign bus.read_data   = rd_req ? rdata_q : 32'h0;
   assign bus.SRAM_ADDR   = addr_q;
   assign bus.SRAM_WE_N   = we_n_q;
   assign bus.SRAM_DQ_OUT = dq_out_q;
   assign bus.SRAM_DQ_OE  = oe_q;
endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller against a word-level access model.
module tb_sram_controller;
   localparam int A = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_controller_if bus ();

   sram_controller #(.ACCESS_CYC(A)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // SRAM pin model and word-level reference memory
   logic [15:0] sram    [0:(1<<18)-1];
   logic [31:0] ref_mem [0:(1<<17)-1];

   // Word-level buffer model
   logic        bvalid = 1'b0;
   logic [16:0] baddr  = '0;
   logic [31:0] bdata  = '0;

   // Per-cycle expectations consumed by the compare process
   logic        exp_on = 1'b0;
   logic        exp_ready, exp_we_n, exp_oe;
   logic        exp_rd_on, exp_addr_on, exp_dq_on;
   logic [31:0] exp_rdata;
   logic [17:0] exp_addr;
   logic [15:0] exp_dq;

   function automatic logic [15:0] init_half(input int a);
      return 16'((a * 40503) ^ 32'h1357);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM array: writes on strobe, read data presented mid-cycle
   always @(posedge clk)
      if (rst && !bus.SRAM_WE_N && bus.SRAM_DQ_OE) sram[bus.SRAM_ADDR] <= bus.SRAM_DQ_OUT;

   always @(negedge clk) bus.SRAM_DQ_IN <= sram[bus.SRAM_ADDR];

   // Compare DUT outputs against the current expectations
   always @(negedge clk) begin
      if (exp_on) begin
         chk("ready", 32'(bus.ready), 32'(exp_ready));
         chk("we_n", 32'(bus.SRAM_WE_N), 32'(exp_we_n));
         chk("dq_oe", 32'(bus.SRAM_DQ_OE), 32'(exp_oe));
         if (exp_rd_on)   chk("read_data", bus.read_data, exp_rdata);
         if (exp_addr_on) chk("sram_addr", 32'(bus.SRAM_ADDR), 32'(exp_addr));
         if (exp_dq_on)   chk("dq_out", 32'(bus.SRAM_DQ_OUT), 32'(exp_dq));
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
         bus.Address = $urandom; bus.Write_data = $urandom;
         exp_on = 1'b1; exp_ready = 1'b1; exp_rd_on = 1'b1; exp_rdata = '0;
         exp_we_n = 1'b1; exp_oe = 1'b0; exp_addr_on = 1'b0; exp_dq_on = 1'b0;
         @(negedge clk);
         @(posedge clk); #1;
      end
   endtask

   // One access: latency 2*A+1 (or 1 on buffer hit); drop>=0 removes the request from cycle drop on.
   task automatic do_access(input bit r, input bit w, input logic [16:0] a, input logic [31:0] d,
                            input int drop, output int lat_obs, output logic [31:0] rd_obs);
      bit hit, pres, act, isrd;
      int lat;
      hit = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
      hit = r && !w && bvalid && (baddr == a);
`endif
      lat = hit ? 1 : 2*A + 1;
      lat_obs = -1; rd_obs = '0;
      for (int k = 0; k <= lat; k++) begin
         pres = (drop < 0) || (k < drop);
         bus.MEM_R_EN   = pres && r;
         bus.MEM_W_EN   = pres && w;
         bus.Address    = {15'($urandom), a};
         bus.Write_data = pres ? d : $urandom;
         act            = !hit && (k >= 1) && (k <= 2*A);
         exp_on      = 1'b1;
         exp_ready   = !pres || (k == lat);
         exp_we_n    = !(w && act);
         exp_oe      = w && act;
         exp_addr_on = act;
         exp_addr    = {a, (k > A)};
         exp_dq_on   = w && act;
         exp_dq      = (k > A) ? d[31:16] : d[15:0];
         isrd        = pres && r && !w;
         exp_rd_on   = !isrd || (k == lat);
         exp_rdata   = !isrd ? 32'h0 : (hit ? bdata : ref_mem[a]);
         @(negedge clk);
         if (pres && bus.ready && lat_obs < 0) begin
            lat_obs = k;
            rd_obs  = bus.read_data;
         end
         @(posedge clk); #1;
      end
      if (w) begin
         ref_mem[a] = d;
         if (bvalid && baddr == a) bvalid = 1'b0;
      end else if (!hit) begin
`ifdef SRAM_READ_BUFFER_EN
         bvalid = 1'b1; baddr = a; bdata = ref_mem[a];
`endif
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, lat2, t, drop;
      logic [31:0] rd, d;
      logic [16:0] a;
      bit          r, w;

      for (int i = 0; i < (1<<18); i++) sram[i] = init_half(i);
      for (int i = 0; i < (1<<17); i++) ref_mem[i] = {init_half(2*i+1), init_half(2*i)};

      rst = 1'b0;
      bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
      bus.Address = '0; bus.Write_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_we_n", 32'(bus.SRAM_WE_N), 32'd1);
      chk("rst_oe", 32'(bus.SRAM_DQ_OE), 32'd0);
      chk("rst_addr", 32'(bus.SRAM_ADDR), 32'd0);
      chk("rst_dq", 32'(bus.SRAM_DQ_OUT), 32'd0);
      chk("rst_rdata", bus.read_data, 32'd0);
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #1;

      // Write 100 <- 0x12345678
      do_access(1'b0, 1'b1, 17'd100, 32'h12345678, -1, lat, rd);
      chk("wr100_lat", 32'(lat), 32'd5);
      chk("wr100_lo", 32'(sram[200]), 32'h5678);
      chk("wr100_hi", 32'(sram[201]), 32'h1234);
      idle(1);

      // Read 100 back, then drop the request
      do_access(1'b1, 1'b0, 17'd100, 32'h0, -1, lat, rd);
      chk("rd100_lat", 32'(lat), 32'd5);
      chk("rd100_data", rd, 32'h12345678);
      idle(1);

      // Read+write together is a write
      do_access(1'b1, 1'b1, 17'd3, 32'h000000FF, -1, lat, rd);
      chk("rw3_rdata", rd, 32'd0);
      chk("rw3_lo", 32'(sram[6]), 32'h00FF);
      chk("rw3_hi", 32'(sram[7]), 32'h0000);
      idle(1);

      // Reset during the high half of a write
      exp_on = 1'b0;
      bus.MEM_W_EN = 1'b1; bus.MEM_R_EN = 1'b0;
      bus.Address = 32'h0001F000; bus.Write_data = 32'hCAFEF00D;
      repeat (A + 1) @(posedge clk);
      #1 chk("pre_rst_half", 32'(bus.SRAM_ADDR), 32'({17'h1F000, 1'b1}));
      #1 rst = 1'b0;
      #1;
      chk("midrst_we_n", 32'(bus.SRAM_WE_N), 32'd1);
      chk("midrst_oe", 32'(bus.SRAM_DQ_OE), 32'd0);
      chk("midrst_ready", 32'(bus.ready), 32'd0);
      bus.MEM_W_EN = 1'b0;
      @(posedge clk); #2 rst = 1'b1;
      bvalid = 1'b0;
      @(posedge clk); #1;
      do_access(1'b1, 1'b0, 17'd7, 32'h0, -1, lat, rd);
      chk("rd7_lat", 32'(lat), 32'd5);

      // Back-to-back reads: second ready 6 cycles after first
      idle(1);
      do_access(1'b1, 1'b0, 17'd101, 32'h0, -1, lat, rd);
      do_access(1'b1, 1'b0, 17'd102, 32'h0, -1, lat2, rd);
      chk("b2b_gap", 32'(lat2 + 1), 32'd6);
      idle(1);

`ifdef SRAM_READ_BUFFER_EN
      do_access(1'b1, 1'b0, 17'd101, 32'h0, -1, lat, rd);
      chk("buf_miss_lat", 32'(lat), 32'd5);
      do_access(1'b1, 1'b0, 17'd101, 32'h0, -1, lat, rd);
      chk("buf_hit_lat", 32'(lat), 32'd1);
      do_access(1'b0, 1'b1, 17'd101, 32'hA5A55A5A, -1, lat, rd);
      do_access(1'b1, 1'b0, 17'd101, 32'h0, -1, lat, rd);
      chk("buf_inval_lat", 32'(lat), 32'd5);
      chk("buf_inval_data", rd, 32'hA5A55A5A);
      idle(1);
`endif

      // Random mix of reads, writes, combined requests and early drops
      for (int i = 0; i < 120; i++) begin
         t = $urandom_range(0, 3);
         r = (t != 2);
         w = (t >= 2);
         a = ($urandom_range(0, 1) == 1) ? 17'($urandom_range(0, 15)) : 17'($urandom_range(100, 103));
         d = $urandom;
         drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : -1;
         do_access(r, w, a, d, drop, lat, rd);
         idle($urandom_range(0, 2));
      end

      exp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: ACCESS_CYC, default 2, cycles each 16-bit half-access occupies (legal range 1..15).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 MEM_R_EN  in  1  read request from MEM stage, held stable until ready=1.
REQ-005 MEM_W_EN  in  1  write request from MEM stage, held stable until ready=1.
REQ-006 Address  in  32  word index; only Address[16:0] used.
REQ-007 Write_data  in  32  store data.
REQ-008 read_data  out  32  load data; 0 whenever MEM_R_EN=0.
REQ-009 ready  out  1  0 freezes pipeline; 1 = access complete or no request.
REQ-010 SRAM_ADDR  out  18  {Address[16:0], half}, half 0 = bits[15:0], 1 = bits[31:16].
REQ-011 SRAM_WE_N  out  1  active-low SRAM write strobe.
REQ-012 SRAM_DQ_OUT  out  16  write data half; SRAM_DQ_OE  out  1  drive enable; SRAM_DQ_IN  in  16  SRAM read data.

Function
REQ-013 The FSM SHALL have states IDLE, LOW, HIGH, DONE; IDLE->LOW on any request; LOW->HIGH and HIGH->DONE after ACCESS_CYC cycles each; DONE->IDLE unconditionally.
REQ-014 ready SHALL equal ~(MEM_R_EN|MEM_W_EN) OR (state==DONE), combinationally.
REQ-015 With a request first present in cycle 0, ready SHALL be 1 in cycle 2*ACCESS_CYC+1 (cycle 5 at default).
REQ-016 Reads: the low half SHALL be captured from SRAM_DQ_IN on the last LOW cycle, the high half on the last HIGH cycle; read_data SHALL be valid in DONE and hold until the next capture.
REQ-017 Writes: SRAM_WE_N=0 and SRAM_DQ_OE=1 throughout LOW (DQ_OUT=Write_data[15:0]) and HIGH (DQ_OUT=Write_data[31:16]); SRAM_WE_N=1, SRAM_DQ_OE=0 in IDLE and DONE.
REQ-018 MEM_R_EN and MEM_W_EN both high SHALL be executed as a write; read_data SHALL be 0 for that access.
REQ-019 SRAM_ADDR half bit SHALL be 0 in LOW, 1 in HIGH; SRAM_ADDR SHALL hold its last value in IDLE/DONE.
REQ-020 A request deasserted before DONE SHALL NOT abort the access; the FSM completes to IDLE.
REQ-021 A new request present in DONE SHALL NOT start until IDLE (one-cycle gap minimum between accesses).

Reset
REQ-022 rst=0 SHALL force, asynchronously: state IDLE, read_data register 0, SRAM_ADDR 0, SRAM_WE_N 1, SRAM_DQ_OUT 0, SRAM_DQ_OE 0, phase counter 0, read buffer invalid.
REQ-023 Reset asserted mid-access SHALL abandon the access; the first post-reset request restarts from LOW.

Configuration
REQ-024 Macro SRAM_READ_BUFFER_EN SHALL compile in a one-entry last-read buffer (address, 32-bit data, valid).
REQ-025 With macro: a read whose Address[16:0] equals the valid buffered address SHALL go IDLE->DONE directly (ready in cycle 1, no SRAM cycles); a write to the buffered address SHALL invalidate the entry; every completed SRAM read SHALL refill it.
REQ-026 Without macro: every read SHALL take the full REQ-015 latency; no buffer storage exists.

Structure
REQ-027 Package sram_ctrl_pkg SHALL hold the state enum, SRAM_ADDR_W=18, SRAM_DQ_W=16, and the ACCESS_CYC default.
REQ-028 The read buffer SHALL be sub-module sram_read_buffer, instantiated only under SRAM_READ_BUFFER_EN.

Verification
REQ-029 Write Address=100, Write_data=0x12345678 -> SRAM_ADDR 200 then 201 with DQ_OUT 0x5678 then 0x1234, WE_N=0 four cycles, ready=1 in cycle 5.
REQ-030 Read Address=100 with SRAM model holding 0x5678/0x1234 -> read_data=0x12345678 and ready=1 in cycle 5; MEM_R_EN dropped -> read_data 0.
REQ-031 MEM_R_EN=MEM_W_EN=1, Address=3, Write_data=0xFF -> write performed, read_data 0.
REQ-032 rst=0 asserted in HIGH of a write -> WE_N=1, DQ_OE=0 immediately; next read Address=7 completes in 5 cycles.
REQ-033 Back-to-back reads Address=101, 102 -> second request's ready rises exactly 6 cycles after first ready (DONE->IDLE gap).
REQ-034 SRAM_READ_BUFFER_EN: read 101, read 101 again -> ready in cycle 1; write 101, read 101 -> full 5-cycle latency, new data returned.
